// File: rtl/muldiv_sequencer.sv
// Sequential 32x32 multiply / 32/32 divide unit with architectural HI/LO registers.
// One multiplier bit or one quotient bit is resolved per clock; signs are fixed up in a final step.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;

  logic        a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic [32:0] sum_s;
  logic [32:0] shifted_s;
  logic [33:0] diff_s;
  logic [63:0] prod_s;

  // Operand magnitudes and per-iteration datapath terms.
  always_comb begin
    a_neg_s   = ~op[0] & a[31];
    b_neg_s   = ~op[0] & b[31];
    a_mag_s   = a_neg_s ? (32'd0 - a) : a;
    b_mag_s   = b_neg_s ? (32'd0 - b) : b;
    // Multiply: acc_lo holds the remaining multiplier bits, product shifts in from the top.
    sum_s     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    shifted_s = {acc_hi_q, acc_lo_q[31]};
    diff_s    = {1'b0, shifted_s} - {2'b00, opnd_q};
    prod_s    = {acc_hi_q, acc_lo_q};
  end

  // Next-state, datapath and HI/LO update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (write_hi) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (write_lo) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
        if (start) begin
          state_d   = CALC;
          cnt_d     = 5'd0;
          is_div_d  = op[1];
          neg_res_d = a_neg_s ^ b_neg_s;
          neg_rem_d = a_neg_s;
          acc_hi_d  = 32'd0;
          if (op[1]) begin
            opnd_d   = b_mag_s;
            acc_lo_d = a_mag_s;
          end else begin
            opnd_d   = a_mag_s;
            acc_lo_d = b_mag_s;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (is_div_q) begin
          if (!diff_s[33]) begin
            acc_hi_d = diff_s[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = shifted_s[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          acc_hi_d = sum_s[32:1];
          acc_lo_d = {sum_s[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (opnd_q == 32'd0) begin
            div0_d = 1'b1;
          end else begin
            hi_d = neg_rem_q ? (32'd0 - acc_hi_q) : acc_hi_q;
            lo_d = neg_res_q ? (32'd0 - acc_lo_q) : acc_lo_q;
          end
        end else begin
          {hi_d, lo_d} = neg_res_q ? (64'd0 - prod_s) : prod_s;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: update m_hi/m_lo as the architecture defines, returning the div0 flag.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic d0);
    longint          sx, sy, sq, sr, sp;
    longint unsigned ux, uy, uq, ur, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    d0 = 1'b0;
    case (o)
      2'b00: begin sp = sx * sy; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      2'b01: begin up = ux * uy; m_hi = up[63:32]; m_lo = up[31:0]; end
      2'b10: begin
        if (y == 32'd0) d0 = 1'b1;
        else begin sq = sx / sy; sr = sx % sy; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      end
      default: begin
        if (y == 32'd0) d0 = 1'b1;
        else begin uq = ux / uy; ur = ux % uy; m_lo = uq[31:0]; m_hi = ur[31:0]; end
      end
    endcase
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one operation; at cycle index ign_at (>=0) drive a spurious start plus HI/LO writes.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic wh, input logic wl,
                        input logic [31:0] wd, input int ign_at);
    logic        e_d0;
    logic        g_d0;
    logic        g_busy_at_done;
    logic [31:0] g_hi, g_lo;
    int          busy_n, done_n, done_at;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    write_hi = wh; write_lo = wl; wdata = wd;
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
    model(o, x, y, e_d0);
    @(posedge clk);
    #1;
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    g_hi = 32'd0; g_lo = 32'd0; g_d0 = 1'b0; g_busy_at_done = 1'b1;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = i; g_hi = hi; g_lo = lo; g_d0 = div0; g_busy_at_done = busy;
        end
      end
      if (i == ign_at) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        write_hi = 1'b1; write_lo = 1'b1; wdata = $urandom;
      end else begin
        start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
      end
    end
    chk({tag, " latency"}, 64'(done_at), 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
    chk({tag, " done_pulses"}, 64'(done_n), 64'd1);
    chk({tag, " busy_at_done"}, {63'd0, g_busy_at_done}, 64'd0);
    chk({tag, " div0"}, {63'd0, g_d0}, {63'd0, e_d0});
    chk({tag, " hi"}, {32'd0, g_hi}, {32'd0, m_hi});
    chk({tag, " lo"}, {32'd0, g_lo}, {32'd0, m_lo});
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    write_hi = 1'b0; write_lo = 1'b0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst div0", {63'd0, div0}, 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // MTHI then divide by zero, with ignored writes/start mid-operation.
    @(negedge clk);
    write_hi = 1'b1; wdata = 32'h0000_1234; m_hi = 32'h0000_1234;
    @(posedge clk);
    #1;
    write_hi = 1'b0;
    @(negedge clk);
    chk("mthi", {32'd0, hi}, 64'h1234);
    run_op("divu0", 2'b11, 32'd77, 32'd0, 1'b0, 1'b0, 32'd0, 5);
    chk("divu0 hi_const", {32'd0, hi}, 64'h1234);

    run_op("mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'd0, -1);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, -1);
    run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, -1);
    run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, -1);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, -1);
    run_op("multu_ign", 2'b01, 32'h0001_2345, 32'h0000_6789, 1'b0, 1'b0, 32'd0, 10);
    run_op("wr_start", 2'b01, 32'd9, 32'd9, 1'b1, 1'b1, 32'hDEAD_BEEF, -1);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst done", {63'd0, done}, 64'd0);
    chk("midrst hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrst no_done", 64'(dn), 64'd0);
    run_op("post_rst", 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, -1);

    for (int t = 0; t < 25; t++) begin
      run_op("rand", 2'($urandom), pick_operand(), pick_operand(),
             1'($urandom), 1'($urandom), $urandom,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock; the only clock.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 start  input  1  request a new operation; sampled at clk edge.
REQ-004 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 a  input  32  operand rs (multiplicand / dividend).
REQ-006 b  input  32  operand rt (multiplier / divisor).
REQ-007 write_hi, write_lo  input  1 each  MTHI / MTLO strobes.
REQ-008 wdata  input  32  data for write_hi / write_lo.
REQ-009 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-010 done  output  1  one-cycle pulse; hi/lo hold the new result while it is high.
REQ-011 div0  output  1  high together with done when a DIV/DIVU had b == 0.
REQ-012 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-013 States SHALL be IDLE, CALC and FIX, with a 5-bit iteration counter cnt.
REQ-014 In IDLE, start=1 at an edge SHALL capture op, a and b, clear cnt and enter CALC; busy SHALL be 1 from the next cycle.
REQ-015 start while busy=1 SHALL be ignored: no capture, and no effect on the operation in progress.
REQ-016 Signed ops (MULT, DIV) SHALL convert the operands to magnitudes at capture and record the result signs.
REQ-017 CALC SHALL perform one iteration per edge, 32 edges total (cnt 0..31). Multiply: shift-add, one multiplier bit per iteration. Divide: restoring, one quotient bit per iteration.
REQ-018 The edge at which cnt==31 SHALL move the block to FIX.
REQ-019 FIX: the next edge SHALL apply the sign correction, write hi/lo, set done=1 for one cycle and return to IDLE.
REQ-020 Timing: for a start accepted at edge k, hi/lo SHALL be updated and done SHALL be high in the cycle after edge k+33; busy SHALL be high after edges k..k+32 and low while done is high.
REQ-021 MULT/MULTU result: {hi,lo} = 64-bit product; MULT SHALL produce the two's-complement signed product.
REQ-022 DIV/DIVU result: lo = quotient, hi = remainder.
REQ-023 DIV SHALL truncate the quotient toward zero; the quotient is negative iff the operand signs differ, and the remainder takes the sign of the dividend.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-025 Divide with b==0 SHALL still take the full latency and pulse done with div0=1; hi and lo SHALL remain unchanged.
REQ-026 write_hi/write_lo SHALL update hi/lo at the edge only when busy=0; they SHALL be ignored while busy=1.
REQ-027 A write coinciding with an accepted start SHALL take effect; the later result overwrites it.
REQ-028 start in the same cycle as done=1 SHALL be accepted, since the state is IDLE.
REQ-029 done and div0 SHALL be registered outputs, never combinational from inputs.

Reset
REQ-030 Asserting reset at any time, including mid-CALC or in FIX, SHALL immediately give state=IDLE, cnt=0, busy=0, done=0, div0=0, hi=0 and lo=0. The interrupted operation SHALL produce no done.
REQ-031 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 -> done at k+33: hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
REQ-035 MTHI 0x1234, then DIVU b=0 -> done with div0=1; hi stays 0x1234 and lo stays 0.
REQ-036 Second start with different operands 10 cycles into a MULTU -> ignored; the original result is produced and there is only one done pulse.
REQ-037 reset pulse at cnt==15 of a DIV -> hi=lo=0, busy=0, no done; a following MULTU 3*4 gives lo=12, hi=0.
